// File: rtl/fetch_unit_rv32i.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_rv32i
// Purpose  : RV32I instruction-fetch stage. Holds the PC, issues a single
//            outstanding instruction-memory read, registers the returned
//            word and exposes its decode fields to the control unit and
//            register file. Accepts PC redirects and stalls on a
//            valid/ready handshake with decode.
// Ports    : clock, reset          - rising-edge clock, sync active-high reset
//            imem_req/imem_addr    - one-cycle read request, address = pc
//            imem_rvalid/rdata     - read response
//            redirect/redirect_pc  - taken branch/jump target
//            out_ready/out_valid   - handshake with decode
//            out_pc/out_instr      - held instruction and its PC
//            opcode..rd            - slices of out_instr
//            misalign_err          - pulse after a redirect with pc[1:0]!=0
//            fetch_count           - accepted-handshake counter (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit_rv32i #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    localparam logic [1:0]  c_ST_FETCH = 2'd0;
    localparam logic [1:0]  c_ST_WAIT  = 2'd1;
    localparam logic [1:0]  c_ST_HOLD  = 2'd2;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;  // ADDI x0,x0,0

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_kill;
    logic        r_out_valid;
    logic [31:0] r_out_pc;
    logic [31:0] r_out_instr;
    logic [31:0] r_fetch_count;
    logic        r_misalign_err;

    // Redirect targets are always word aligned; low bits only flag an error.
    logic [31:0] w_redirect_target;
    assign w_redirect_target = {redirect_pc[31:2], 2'b00};

    // The request is suppressed when a redirect arrives in the same cycle so
    // the next read goes straight to the new target.
    assign imem_req     = (r_state == c_ST_FETCH) & ~redirect;
    assign imem_addr    = r_pc;
    assign out_valid    = r_out_valid;
    assign out_pc       = r_out_pc;
    assign out_instr    = r_out_instr;
    assign misalign_err = r_misalign_err;
    assign fetch_count  = r_fetch_count;

    assign opcode = r_out_instr[6:0];
    assign rd     = r_out_instr[11:7];
    assign funct3 = r_out_instr[14:12];
    assign rs1    = r_out_instr[19:15];
    assign rs2    = r_out_instr[24:20];
    assign funct7 = r_out_instr[31:25];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= c_ST_FETCH;
            r_pc           <= RESET_PC;
            r_kill         <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_pc       <= RESET_PC;
            r_out_instr    <= c_NOP;
            r_fetch_count  <= 32'd0;
            r_misalign_err <= 1'b0;
        end else begin
            r_misalign_err <= redirect & (redirect_pc[1:0] != 2'b00);

            case (r_state)
                c_ST_FETCH: begin
                    // Any response still in flight here belongs to an
                    // abandoned request and is ignored.
                    if (redirect) begin
                        r_pc <= w_redirect_target;
                    end else begin
                        r_state <= c_ST_WAIT;
                    end
                end

                c_ST_WAIT: begin
                    // A redirect while waiting cannot cancel the read already
                    // issued; remember to drop its data when it arrives.
                    if (redirect) begin
                        r_pc   <= w_redirect_target;
                        r_kill <= 1'b1;
                    end
                    if (imem_rvalid) begin
                        if (r_kill | redirect) begin
                            r_kill  <= 1'b0;
                            r_state <= c_ST_FETCH;
                        end else begin
                            r_out_instr <= imem_rdata;
                            r_out_pc    <= r_pc;
                            r_pc        <= r_pc + 32'd4;
                            r_out_valid <= 1'b1;
                            r_state     <= c_ST_HOLD;
                        end
                    end
                end

                c_ST_HOLD: begin
                    // Redirect beats the handshake: the held instruction is
                    // on the wrong path and must not be counted.
                    if (redirect) begin
                        r_out_valid <= 1'b0;
                        r_pc        <= w_redirect_target;
                        r_state     <= c_ST_FETCH;
                    end else if (out_ready) begin
                        r_out_valid   <= 1'b0;
                        r_fetch_count <= r_fetch_count + 32'd1;
                        r_state       <= c_ST_FETCH;
                    end
                end

                default: begin
                    r_state <= c_ST_FETCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit_rv32i.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit_rv32i
// Purpose  : Self-checking bench for fetch_unit_rv32i. A cycle-level
//            behavioural model (pc / in-flight / holding flags) is compared
//            against the DUT every cycle; a vector table and hand-written
//            sequences cover the directed scenarios, followed by a
//            randomized run with variable memory latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit_rv32i;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i    = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] rpc_i      = 32'd0;
    logic        ready_i    = 1'b0;
    logic        rvalid_i   = 1'b0;
    logic [31:0] rdata_i    = 32'd0;

    logic        req, valid, mis;
    logic [31:0] addr, opc, instr, cnt;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;

    logic        h_req, h_valid, h_mis;
    logic [31:0] h_addr, h_pc, h_instr, h_cnt;
    logic [6:0]  h_opcode, h_f7;
    logic [2:0]  h_f3;
    logic [4:0]  h_rs1, h_rs2, h_rd;

    fetch_unit_rv32i #(.RESET_PC(32'h0000_0000)) dut (
        .clock(clk), .reset(reset_i), .imem_req(req), .imem_addr(addr),
        .imem_rvalid(rvalid_i), .imem_rdata(rdata_i), .redirect(redirect_i),
        .redirect_pc(rpc_i), .out_ready(ready_i), .out_valid(valid),
        .out_pc(opc), .out_instr(instr), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd),
        .misalign_err(mis), .fetch_count(cnt)
    );

    // Second instance sees identical stimulus; only its PC differs, so its
    // handshake timing tracks the first instance exactly.
    fetch_unit_rv32i #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
        .clock(clk), .reset(reset_i), .imem_req(h_req), .imem_addr(h_addr),
        .imem_rvalid(rvalid_i), .imem_rdata(rdata_i), .redirect(redirect_i),
        .redirect_pc(rpc_i), .out_ready(ready_i), .out_valid(h_valid),
        .out_pc(h_pc), .out_instr(h_instr), .opcode(h_opcode), .funct3(h_f3),
        .funct7(h_f7), .rs1(h_rs1), .rs2(h_rs2), .rd(h_rd),
        .misalign_err(h_mis), .fetch_count(h_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0033;
        if (a == 32'h4) return 32'h4000_0033;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // ---------------- memory responder ----------------
    logic        mem_en   = 1'b1;
    logic        mem_pend = 1'b0;
    int          mem_cnt  = 0;
    int          mem_lat  = 1;
    logic [31:0] mem_addr = 32'd0;
    logic        man_rvalid = 1'b0;
    logic [31:0] man_rdata  = 32'd0;

    // ---------------- reference model ----------------
    logic        model_ok = 1'b0;
    logic [31:0] m_pc, m_opc, m_instr, m_count;
    logic        m_inflight, m_have, m_kill, m_mis;

    task automatic model_update();
        logic [31:0] tgt;
        logic        drop;
        tgt = rpc_i & 32'hFFFF_FFFC;
        if (reset_i) begin
            m_pc = 32'h0; m_opc = 32'h0; m_instr = 32'h13; m_count = 0;
            m_inflight = 0; m_have = 0; m_kill = 0; m_mis = 0;
            model_ok = 1'b1;
        end else begin
            m_mis = redirect_i && (rpc_i % 4 != 0);
            if (m_have) begin
                if (redirect_i) begin m_have = 0; m_pc = tgt; end
                else if (ready_i) begin m_have = 0; m_count = m_count + 1; end
            end else if (m_inflight) begin
                drop = m_kill || redirect_i;
                if (redirect_i) m_pc = tgt;
                if (rvalid_i) begin
                    m_inflight = 0;
                    m_kill = 0;
                    if (!drop) begin
                        m_opc = m_pc; m_instr = rdata_i; m_pc = m_pc + 4; m_have = 1;
                    end
                end else if (redirect_i) begin
                    m_kill = 1;
                end
            end else begin
                if (redirect_i) m_pc = tgt;
                else m_inflight = 1;
            end
        end
    endtask

    task automatic model_compare();
        chk("m.req",    {31'd0, req}, {31'd0, !m_inflight && !m_have && !redirect_i});
        chk("m.addr",   addr, m_pc);
        chk("m.valid",  {31'd0, valid}, {31'd0, m_have});
        chk("m.out_pc", opc, m_opc);
        chk("m.instr",  instr, m_instr);
        chk("m.opcode", {25'd0, opcode}, m_instr & 32'h7F);
        chk("m.rd",     {27'd0, rd},     (m_instr >> 7)  & 32'h1F);
        chk("m.funct3", {29'd0, funct3}, (m_instr >> 12) & 32'h7);
        chk("m.rs1",    {27'd0, rs1},    (m_instr >> 15) & 32'h1F);
        chk("m.rs2",    {27'd0, rs2},    (m_instr >> 20) & 32'h1F);
        chk("m.funct7", {25'd0, funct7}, (m_instr >> 25) & 32'h7F);
        chk("m.mis",    {31'd0, mis}, {31'd0, m_mis});
        chk("m.count",  cnt, m_count);
    endtask

    // Inputs for the cycle are already set; present memory response, settle.
    task automatic begin_cycle();
        if (mem_en) begin
            if (mem_pend && mem_cnt == 1) begin
                rvalid_i = 1'b1; rdata_i = mem_word(mem_addr); mem_pend = 1'b0;
            end else begin
                if (mem_pend) mem_cnt--;
                rvalid_i = 1'b0; rdata_i = $urandom;
            end
        end else begin
            rvalid_i = man_rvalid; rdata_i = man_rdata;
        end
        #1;
        if (model_ok) model_compare();
    endtask

    task automatic end_cycle();
        logic        s_req;
        logic [31:0] s_addr;
        s_req = req; s_addr = addr;
        @(posedge clk);
        model_update();
        if (reset_i) mem_pend = 1'b0;
        else if (mem_en && s_req) begin
            mem_pend = 1'b1; mem_addr = s_addr; mem_cnt = mem_lat;
        end
        #1;
    endtask

    task automatic cyc();
        begin_cycle();
        end_cycle();
    endtask

    task automatic do_reset();
        reset_i = 1'b1; redirect_i = 1'b0; ready_i = 1'b1;
        mem_pend = 1'b0; mem_en = 1'b1; mem_lat = 1;
        cyc(); cyc();
        reset_i = 1'b0;
    endtask

    typedef struct {
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [31:0] exp_cnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic q, input logic [31:0] a,
                                input logic v, input logic [31:0] p,
                                input logic [31:0] i, input logic [31:0] c);
        vec_t t;
        t.ready = r; t.exp_req = q; t.exp_addr = a; t.exp_valid = v;
        t.exp_pc = p; t.exp_instr = i; t.exp_cnt = c;
        return t;
    endfunction

    vec_t tbl[15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] m8;
        logic [31:0] k;
        m8 = mem_word(32'h8);
        // 1-cycle memory; two back-to-back fetches, then a 5-cycle stall.
        tbl[0]  = mk(1, 1, 32'h0, 0, 32'h0, 32'h13,        0);
        tbl[1]  = mk(1, 0, 32'h0, 0, 32'h0, 32'h13,        0);
        tbl[2]  = mk(1, 0, 32'h4, 1, 32'h0, 32'h33,        0);
        tbl[3]  = mk(1, 1, 32'h4, 0, 32'h0, 32'h33,        1);
        tbl[4]  = mk(1, 0, 32'h4, 0, 32'h0, 32'h33,        1);
        tbl[5]  = mk(1, 0, 32'h8, 1, 32'h4, 32'h4000_0033, 1);
        tbl[6]  = mk(0, 1, 32'h8, 0, 32'h4, 32'h4000_0033, 2);
        tbl[7]  = mk(0, 0, 32'h8, 0, 32'h4, 32'h4000_0033, 2);
        for (int i = 8; i < 13; i++) tbl[i] = mk(0, 0, 32'hC, 1, 32'h8, m8, 2);
        tbl[13] = mk(1, 0, 32'hC, 1, 32'h8, m8, 2);
        tbl[14] = mk(0, 1, 32'hC, 0, 32'h8, m8, 3);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            ready_i = tbl[i].ready;
            begin_cycle();
            chk($sformatf("t[%0d].req", i),   {31'd0, req},   {31'd0, tbl[i].exp_req});
            chk($sformatf("t[%0d].addr", i),  addr,           tbl[i].exp_addr);
            chk($sformatf("t[%0d].valid", i), {31'd0, valid}, {31'd0, tbl[i].exp_valid});
            chk($sformatf("t[%0d].pc", i),    opc,            tbl[i].exp_pc);
            chk($sformatf("t[%0d].instr", i), instr,          tbl[i].exp_instr);
            k = tbl[i].exp_instr;
            chk($sformatf("t[%0d].opcode", i), {25'd0, opcode}, {25'd0, k[6:0]});
            chk($sformatf("t[%0d].funct7", i), {25'd0, funct7}, {25'd0, k[31:25]});
            chk($sformatf("t[%0d].count", i), cnt,            tbl[i].exp_cnt);
            end_cycle();
        end

        // Redirect while waiting on a 3-cycle memory.
        do_reset();
        mem_lat = 3;
        cyc();
        redirect_i = 1'b1; rpc_i = 32'h0000_0100;
        begin_cycle(); chk("wr.valid_b", {31'd0, valid}, 32'd0); end_cycle();
        redirect_i = 1'b0;
        begin_cycle(); chk("wr.addr_c", addr, 32'h100); chk("wr.req_c", {31'd0, req}, 32'd0); end_cycle();
        begin_cycle(); chk("wr.valid_d", {31'd0, valid}, 32'd0); end_cycle();
        begin_cycle();
        chk("wr.req_e", {31'd0, req}, 32'd1); chk("wr.addr_e", addr, 32'h100);
        chk("wr.valid_e", {31'd0, valid}, 32'd0);
        end_cycle();
        begin_cycle(); chk("wr.valid_f", {31'd0, valid}, 32'd0); end_cycle();

        // Misaligned redirect in HOLD together with out_ready.
        do_reset();
        cyc(); cyc();
        redirect_i = 1'b1; rpc_i = 32'h0000_0203; ready_i = 1'b1;
        begin_cycle(); chk("hr.valid_c", {31'd0, valid}, 32'd1); end_cycle();
        redirect_i = 1'b0;
        begin_cycle();
        chk("hr.mis_d", {31'd0, mis}, 32'd1); chk("hr.valid_d", {31'd0, valid}, 32'd0);
        chk("hr.req_d", {31'd0, req}, 32'd1); chk("hr.addr_d", addr, 32'h200);
        chk("hr.count_d", cnt, 32'd0);
        end_cycle();
        begin_cycle(); chk("hr.mis_e", {31'd0, mis}, 32'd0); chk("hr.count_e", cnt, 32'd0); end_cycle();

        // Reset while waiting, stale response right after reset releases.
        do_reset();
        cyc(); cyc(); cyc();
        mem_en = 1'b0; man_rvalid = 1'b0;
        cyc();
        reset_i = 1'b1;
        cyc();
        reset_i = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF;
        begin_cycle();
        chk("rs.req", {31'd0, req}, 32'd1); chk("rs.addr", addr, 32'h0);
        chk("rs.valid", {31'd0, valid}, 32'd0); chk("rs.pc", opc, 32'h0);
        chk("rs.instr", instr, 32'h13); chk("rs.count", cnt, 32'd0);
        chk("rs.mis", {31'd0, mis}, 32'd0);
        end_cycle();
        man_rdata = 32'h0050_0093;
        begin_cycle(); chk("rs.valid_g", {31'd0, valid}, 32'd0); chk("rs.instr_g", instr, 32'h13); end_cycle();
        man_rvalid = 1'b0;
        begin_cycle();
        chk("rs.valid_h", {31'd0, valid}, 32'd1); chk("rs.instr_h", instr, 32'h0050_0093);
        chk("rs.pc_h", opc, 32'h0);
        end_cycle();
        mem_en = 1'b1; mem_pend = 1'b0;

        // PC wrap from the top of the address space (second instance).
        do_reset();
        begin_cycle(); chk("wrap.req_a", {31'd0, h_req}, 32'd1); chk("wrap.addr_a", h_addr, 32'hFFFF_FFFC); end_cycle();
        cyc();
        begin_cycle();
        chk("wrap.valid", {31'd0, h_valid}, 32'd1); chk("wrap.pc", h_pc, 32'hFFFF_FFFC);
        chk("wrap.addr_c", h_addr, 32'h0); chk("wrap.instr", h_instr, 32'h33);
        chk("wrap.opcode", {25'd0, h_opcode}, 32'h33); chk("wrap.f3", {29'd0, h_f3}, 32'd0);
        chk("wrap.f7", {25'd0, h_f7}, 32'd0); chk("wrap.rs1", {27'd0, h_rs1}, 32'd0);
        chk("wrap.rs2", {27'd0, h_rs2}, 32'd0); chk("wrap.rd", {27'd0, h_rd}, 32'd0);
        chk("wrap.mis", {31'd0, h_mis}, 32'd0); chk("wrap.cnt_c", h_cnt, 32'd0);
        end_cycle();
        begin_cycle();
        chk("wrap.req_d", {31'd0, h_req}, 32'd1); chk("wrap.addr_d", h_addr, 32'h0);
        chk("wrap.cnt_d", h_cnt, 32'd1);
        end_cycle();

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            reset_i    = ($urandom % 150) == 0;
            redirect_i = ($urandom % 7) == 0;
            rpc_i      = $urandom;
            ready_i    = ($urandom % 3) != 0;
            mem_lat    = $urandom_range(1, 4);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit_rv32i.md
# fetch_unit_rv32i

Instruction-fetch stage for the RV32I core. It holds the program counter, issues one instruction-memory read at a time, and registers the returned word. It also splits that word into the fields (opcode, funct3, funct7, rs1, rs2, rd) that feed ctrl_unit_rv32i and the register file. It accepts PC redirects from branch/jump resolution and stalls on a valid/ready handshake with the decode stage.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 00.

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  read request, valid for one cycle.
- imem_addr  out  32  byte address of the read; always equals pc.
- imem_rvalid  in  1  read data valid; arrives at least 1 cycle after imem_req.
- imem_rdata  in  32  instruction word.
- redirect  in  1  branch/jump taken; load redirect_pc.
- redirect_pc  in  32  new PC target.
- out_ready  in  1  decode stage accepts the held instruction.
- out_valid  out  1  held instruction is valid.
- out_pc  out  32  PC of the held instruction.
- out_instr  out  32  held instruction word.
- opcode  out  7  out_instr[6:0].
- funct3  out  3  out_instr[14:12].
- funct7  out  7  out_instr[31:25].
- rs1  out  5  out_instr[19:15].
- rs2  out  5  out_instr[24:20].
- rd  out  5  out_instr[11:7].
- misalign_err  out  1  one-cycle pulse when redirect_pc[1:0] != 00.
- fetch_count  out  32  number of out_valid & out_ready handshakes; wraps modulo 2^32.

## Operation
- FSM states: FETCH, WAIT, HOLD. At most one memory request is outstanding.
- FETCH:
  - imem_req = ~redirect.
  - If redirect: pc <= {redirect_pc[31:2],2'b00} and stay in FETCH.
  - Otherwise go to WAIT.
  - imem_rvalid is ignored in this state.
- WAIT:
  - If redirect: pc <= redirect target and kill <= 1.
  - On imem_rvalid with kill=1 or redirect=1: discard the data, clear kill, go to FETCH.
  - On imem_rvalid with no kill and no redirect: out_instr <= imem_rdata, out_pc <= pc, pc <= pc+4, out_valid <= 1, go to HOLD.
- HOLD:
  - out_valid = 1, and out_instr/out_pc stay stable until the handshake.
  - Redirect has priority over out_ready: out_valid <= 0, pc <= redirect target, go to FETCH. The held instruction is dropped and not counted.
  - Else if out_ready: out_valid <= 0, fetch_count <= fetch_count+1, go to FETCH.
- Field outputs are combinational slices of out_instr.
- pc+4 wraps from 32'hFFFF_FFFC to 32'h0000_0000.
- misalign_err is registered. It pulses in the cycle after any redirect whose redirect_pc[1:0] != 00, in any state. The target's low two bits are forced to 00.

## Timing
Reset values (registered on the clock edge where reset=1):
- state=FETCH, pc=RESET_PC, kill=0, out_valid=0.
- out_pc=RESET_PC.
- out_instr=32'h0000_0013 (ADDI x0,x0,0), so the field outputs decode as a NOP.
- fetch_count=0, misalign_err=0.

Cycle behaviour:
- imem_req is high in the first cycle after reset deasserts.
- Reset asserted mid-operation in any state abandons any outstanding request. A late imem_rvalid arriving in FETCH is ignored.
- Latency: out_valid rises the cycle after the accepted imem_rvalid. With 1-cycle memory and out_ready=1, one instruction completes every 3 cycles (FETCH, WAIT, HOLD).
- Simultaneous redirect and imem_rvalid in WAIT: the response is discarded and the next request uses the redirect target.
- Simultaneous redirect and out_ready in HOLD: the redirect wins and fetch_count does not increment.

## Test plan
1. Reset with RESET_PC=0, 1-cycle memory, out_ready=1, imem_rdata = 32'h0000_0033 at addr 0 and 32'h4000_0033 at addr 4 -> imem_addr sequence 0, 4, 8. First out_valid has out_pc=0, opcode=7'h33, funct7=7'h00. Second has funct7=7'h20. fetch_count=2 after two handshakes.
2. out_ready held 0 for 5 cycles in HOLD -> out_valid, out_instr and out_pc stay stable, imem_req stays 0, fetch_count is unchanged. Then out_ready=1 for one cycle -> fetch_count increments by 1, and the next imem_addr is out_pc+4.
3. Redirect to 32'h0000_0100 while in WAIT with 3-cycle memory latency -> the returned word is discarded (out_valid stays 0), and the next imem_addr is 32'h0000_0100.
4. Redirect to 32'h0000_0203 in HOLD together with out_ready=1 -> misalign_err pulses for exactly 1 cycle, out_valid drops, the next imem_addr is 32'h0000_0200, and fetch_count is unchanged.
5. RESET_PC=32'hFFFF_FFFC, one fetch completes -> the next imem_addr is 32'h0000_0000.
6. Reset asserted in WAIT with imem_rvalid arriving 1 cycle after reset deasserts -> that response is ignored, all outputs return to their reset values, and imem_req=1 with imem_addr=RESET_PC.
